// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with req/ack bus, big-endian byte lanes and load extension.
// Define MEM_ALIGN_EXC_EN to trap misaligned half/word accesses instead of issuing them.
module mem_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
`ifdef MEM_ALIGN_EXC_EN
  ,output logic       align_exc_o
`endif
);
  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_req, r_abort, r_err;
  logic        w_lb, w_lbu, w_lh, w_lhu, w_lw, w_sb, w_sh, w_sw;
  logic        w_ld, w_st, w_mem, w_byte, w_half, w_word, w_mis, w_to, w_on, w_done;
  logic [1:0]  w_a;
  logic [3:0]  w_sel;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic [31:0] w_wdata, w_ldata, w_shift;
  always_comb begin
    w_lb   = aluop_i == EXE_LB_OP;
    w_lbu  = aluop_i == EXE_LBU_OP;
    w_lh   = aluop_i == EXE_LH_OP;
    w_lhu  = aluop_i == EXE_LHU_OP;
    w_lw   = aluop_i == EXE_LW_OP;
    w_sb   = aluop_i == EXE_SB_OP;
    w_sh   = aluop_i == EXE_SH_OP;
    w_sw   = aluop_i == EXE_SW_OP;
    w_ld   = w_lb | w_lbu | w_lh | w_lhu | w_lw;
    w_st   = w_sb | w_sh | w_sw;
    w_mem  = w_ld | w_st;
    w_byte = w_lb | w_lbu | w_sb;
    w_half = w_lh | w_lhu | w_sh;
    w_word = w_lw | w_sw;
    w_a    = mem_addr_i[1:0];
    w_sel  = w_byte ? 4'b1000 >> w_a : w_half ? (w_a[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    w_wdata = w_byte ? {4{reg2_i[7:0]}} : w_half ? {2{reg2_i[15:0]}} : reg2_i;
    // Lane 0 (a=0) is the most significant byte, so shift right by (3-a) bytes.
    w_shift = bus_rdata_i >> {~w_a, 3'b000};
    w_b     = w_shift[7:0];
    w_h     = w_a[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
    w_ldata = w_lb  ? {{24{w_b[7]}}, w_b} :
              w_lbu ? {24'd0, w_b} :
              w_lh  ? {{16{w_h[15]}}, w_h} :
              w_lhu ? {16'd0, w_h} : bus_rdata_i;
`ifdef MEM_ALIGN_EXC_EN
    w_mis  = (w_half & w_a[0]) | (w_word & |w_a);
`else
    w_mis  = 1'b0;
`endif
    w_to   = r_state == S_BUSY && !bus_ack_i && r_cnt == 8'(TIMEOUT - 1);
    w_on   = r_req & !rst;
    w_done = r_state == S_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_rdata <= 32'd0;
      r_req   <= 1'b0;
      r_abort <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_to;
      if (r_state == S_IDLE) begin
        r_cnt <= 8'd0;
        if (w_mem) begin
          r_state <= w_mis ? S_DONE : S_BUSY;
          r_req   <= !w_mis;
          r_abort <= w_mis;
        end
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 8'd1;
        if (bus_ack_i) begin
          r_req   <= 1'b0;
          r_rdata <= w_ldata;
          r_abort <= 1'b0;
          r_state <= S_DONE;
        end else if (w_to) begin
          r_req   <= 1'b0;
          r_abort <= 1'b1;
          r_state <= S_DONE;
        end
      end else begin
        r_state <= S_IDLE;
      end
    end
  end
`ifdef MEM_ALIGN_EXC_EN
  logic r_aexc;
  always_ff @(posedge clk) begin
    if (rst) r_aexc <= 1'b0;
    else r_aexc <= r_state == S_IDLE && w_mem && w_mis;
  end
  assign align_exc_o = r_aexc;
`endif
  always_comb begin
    stallreq_o  = !rst & ((r_state == S_IDLE & w_mem) | r_state == S_BUSY);
    wd_o        = rst ? 5'd0 : wd_i;
    wreg_o      = rst ? 1'b0 : !w_mem ? wreg_i : w_done & !r_abort & wreg_i;
    wdata_o     = rst ? 32'd0 : !w_mem ? wdata_i : (w_done & w_ld & !r_abort) ? r_rdata : 32'd0;
    bus_req_o   = w_on;
    bus_we_o    = w_on & w_st;
    bus_addr_o  = w_on ? {mem_addr_i[31:2], 2'b00} : 32'd0;
    bus_sel_o   = w_on ? w_sel : 4'd0;
    bus_wdata_o = (w_on & w_st) ? w_wdata : 32'd0;
    bus_err_o   = r_err & !rst;
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed plus random load/store transactions checked against a byte-level model.
module tb_mem_lsu;
  localparam int TO = 4;
  localparam logic [7:0] OR_OP = 8'b00100101;
  localparam logic [7:0] LB = 8'b11100000, LBU = 8'b11100100, LH = 8'b11100001, LHU = 8'b11100101;
  localparam logic [7:0] LW = 8'b11100011, SB = 8'b11101000, SH = 8'b11101001, SW = 8'b11101011;
  logic clk = 0, rst = 1;
  logic [7:0] aluop_i = 0;
  logic [31:0] mem_addr_i = 0, reg2_i = 0, wdata_i = 0, bus_rdata_i = 0;
  logic [4:0] wd_i = 0;
  logic wreg_i = 0, bus_ack_i = 0;
  logic [4:0] wd_o;
  logic wreg_o, stallreq_o, bus_req_o, bus_we_o, bus_err_o;
  logic [31:0] wdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0] bus_sel_o;
  int total = 0, bad = 0;
  mem_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .stallreq_o(stallreq_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int op_size(input logic [7:0] op);
    return (op == LB || op == LBU || op == SB) ? 1 : (op == LH || op == LHU || op == SH) ? 2 : 4;
  endfunction
  task automatic run(input logic [7:0] op, input logic [31:0] addr, rt, rd, input int ack_at,
                     input logic [4:0] wd, input logic wr, input bit late);
    int sz, st, busy;
    bit is_st, sgn, done;
    logic [3:0] esel;
    logic [31:0] ewd, eld;
    sz = op_size(op);
    is_st = op == SB || op == SH || op == SW;
    sgn = op == LB || op == LH;
    st = sz == 1 ? int'(addr[1:0]) : sz == 2 ? int'(addr[1]) * 2 : 0;
    esel = 0;
    eld = 0;
    for (int k = st; k < st + sz; k++) begin
      esel[3-k] = 1'b1;
      eld = (eld << 8) | 32'(rd[8*(3-k) +: 8]);
    end
    if (sgn && eld[8*sz-1]) eld = eld | ~((32'd1 << (8*sz)) - 32'd1);
    for (int k = 0; k < 4; k++) ewd[8*k +: 8] = rt[8*(k % sz) +: 8];
    @(negedge clk);
    aluop_i = op; mem_addr_i = addr; reg2_i = rt; wd_i = wd; wreg_i = wr;
    wdata_i = $urandom; bus_rdata_i = rd; bus_ack_i = 0;
    #1 chk("entry_stall", stallreq_o, 1);
    chk("entry_req", bus_req_o, 0);
    busy = 0;
    done = 0;
    for (int n = 1; n <= 300 && !done; n++) begin
      @(negedge clk); #1;
      if (stallreq_o) begin
        busy++;
        chk("busy_req", bus_req_o, 1);
        if (busy == 1) begin
          chk("bus_addr", bus_addr_o, {addr[31:2], 2'b00});
          chk("bus_sel", bus_sel_o, esel);
          chk("bus_we", bus_we_o, is_st);
          chk("bus_wdata", bus_wdata_o, is_st ? ewd : 32'd0);
        end
        bus_ack_i = busy == ack_at;
      end else begin
        done = 1;
        bus_ack_i = 0;
        chk("busy_cycles", busy, ack_at != 0 ? ack_at : TO);
        chk("done_req", bus_req_o, 0);
        chk("done_err", bus_err_o, ack_at == 0);
        chk("done_wd", wd_o, wd);
        chk("done_wreg", wreg_o, ack_at != 0 && wr);
        chk("done_wdata", wdata_o, (ack_at == 0 || is_st) ? 32'd0 : eld);
      end
    end
    if (!done) chk("no_done", 0, 1);
    @(posedge clk); #1;
    aluop_i = OR_OP; wreg_i = 0; wdata_i = 0; bus_ack_i = late;
    @(negedge clk); #1;
    chk("after_stall", stallreq_o, 0);
    chk("after_req", bus_req_o, 0);
    chk("after_err", bus_err_o, 0);
    bus_ack_i = 0;
  endtask
  initial begin
    logic [7:0] ops [8];
    logic [7:0] op;
    ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW};
    aluop_i = OR_OP; wdata_i = 32'h55; wreg_i = 1; wd_i = 7;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_wdata", wdata_o, 0);
    chk("rst_wreg", wreg_o, 0);
    chk("rst_wd", wd_o, 0);
    chk("rst_stall", stallreq_o, 0);
    chk("rst_req", bus_req_o, 0);
    chk("rst_err", bus_err_o, 0);
    chk("rst_sel", bus_sel_o, 0);
    rst = 0;
    @(negedge clk);
    aluop_i = OR_OP; wdata_i = 32'h1234; wd_i = 3; wreg_i = 1;
    #1 chk("nop_wdata", wdata_o, 32'h1234);
    chk("nop_wd", wd_o, 3);
    chk("nop_wreg", wreg_o, 1);
    chk("nop_stall", stallreq_o, 0);
    chk("nop_req", bus_req_o, 0);
    run(LB, 32'h103, 0, 32'h000000F0, 3, 5'd4, 1, 0);
    run(LBU, 32'h103, 0, 32'h000000F0, 3, 5'd4, 1, 0);
    run(SH, 32'h202, 32'hAABBCCDD, 0, 1, 5'd0, 0, 0);
    run(LW, 32'h300, 0, 32'hDEADBEEF, 0, 5'd9, 1, 1);
    run(LW, 32'h101, 0, 32'h89ABCDEF, 2, 5'd10, 1, 0);
    run(LH, 32'h401, 0, 32'h12348765, TO, 5'd11, 1, 0);
    @(negedge clk);
    aluop_i = LW; mem_addr_i = 32'h500; wd_i = 12; wreg_i = 1; bus_ack_i = 0;
    repeat (2) @(negedge clk);
    #1 chk("pre_rst_req", bus_req_o, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("rstbusy_req", bus_req_o, 0);
    chk("rstbusy_stall", stallreq_o, 0);
    @(negedge clk);
    rst = 0; aluop_i = OR_OP; wreg_i = 0; wdata_i = 0; bus_ack_i = 1;
    @(negedge clk); #1;
    bus_ack_i = 0;
    chk("rstbusy_wreg", wreg_o, 0);
    chk("rstbusy_idle", stallreq_o, 0);
    chk("rstbusy_req2", bus_req_o, 0);
    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 7)];
      run(op, $urandom, $urandom, $urandom, $urandom_range(0, TO), 5'($urandom),
          op[3] ? 1'b0 : 1'b1, 1'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
